// File: rtl/access_pkg.sv
// Shared types and constants for the access datapath pushbutton logic.
package access_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_PULSE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  localparam logic BTN_PRESSED = 1'b0;

endpackage

// File: rtl/button_shaper_debounce_filter.sv
// Two-flop synchronizer followed by a counter-based debounce filter.
module debounce_filter
  import access_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic b_in,
  output logic b_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1  <= ~BTN_PRESSED;
      s2  <= ~BTN_PRESSED;
      db  <= ~BTN_PRESSED;
      cnt <= '0;
    end else begin
      s1 <= b_in;
      s2 <= s1;
      // Any cycle agreeing with db restarts the count, so bounces only delay settling.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign b_held = (db == BTN_PRESSED);

endmodule

// File: rtl/button_shaper.sv
// Turns a bouncing active-low pushbutton into one active-high pulse per press.
module button_shaper
  import access_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic b_in,
  output logic b_out,
  output logic b_held
);

  state_t state;
  state_t next_state;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .b_in  (b_in),
    .b_held(b_held)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_INIT;
    b_out      = 1'b0;
    case (state)
      S_INIT:  next_state = b_held ? S_PULSE : S_INIT;
      S_PULSE: begin
        b_out      = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT:  next_state = b_held ? S_WAIT : S_INIT;
      default: next_state = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_button_shaper.sv
// Directed bench for button_shaper with the default debounce length of 4.
module tb_button_shaper;
  import access_pkg::*;

  logic       clk;
  logic       rst;
  logic       b_in;
  logic       b_out;
  logic       b_held;
  logic [3:0] load_i;
  logic [3:0] load_q;

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;

  button_shaper #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .b_in  (b_in),
    .b_out (b_out),
    .b_held(b_held)
  );

  // Downstream 4-bit load register driven by the shaped pulse.
  always_ff @(posedge clk) begin
    if (!rst) load_q <= '0;
    else if (b_out) load_q <= load_i;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive b_in, advance one rising edge, then settle so outputs reflect that edge.
  task automatic cyc(input logic bin);
    b_in = bin;
    @(posedge clk);
    #1;
    if (b_out === 1'b1) pulses++;
  endtask

  initial begin
    rst    = 1'b0;
    b_in   = 1'b1;
    load_i = 4'h0;

    // Reset then idle
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1);
      check("rst_out", 8'(b_out), 8'd0);
      check("rst_held", 8'(b_held), 8'd0);
    end
    check("rst_state", 8'(dut.state), 8'(S_INIT));
    rst = 1'b1;
    for (int j = 0; j < 20; j++) begin
      cyc(1'b1);
      check("idle_out", 8'(b_out), 8'd0);
      check("idle_held", 8'(b_held), 8'd0);
    end

    // Clean press: j=0 is edge E
    pulses = 0;
    for (int j = 0; j < 30; j++) begin
      cyc(1'b0);
      check($sformatf("press_held_%0d", j), 8'(b_held), 8'(j >= 5));
      check($sformatf("press_out_%0d", j), 8'(b_out), 8'(j == 6));
    end
    check("press_pulses", 8'(pulses), 8'd1);

    // Release: held falls 5 edges after first released sample
    for (int j = 0; j < 12; j++) begin
      cyc(1'b1);
      check($sformatf("rel_held_%0d", j), 8'(b_held), 8'(j < 5));
      check($sformatf("rel_out_%0d", j), 8'(b_out), 8'd0);
    end
    check("rel_state", 8'(dut.state), 8'(S_INIT));

    // Bounce, then stable low from j=12
    pulses = 0;
    for (int j = 0; j < 32; j++) begin
      cyc((j < 12) ? logic'((j / 2) % 2) : 1'b0);
      check($sformatf("bnc_held_%0d", j), 8'(b_held), 8'(j >= 17));
      check($sformatf("bnc_out_%0d", j), 8'(b_out), 8'(j == 18));
    end
    check("bnc_pulses", 8'(pulses), 8'd1);
    for (int j = 0; j < 12; j++) cyc(1'b1);
    check("bnc_rel_held", 8'(b_held), 8'd0);

    // Glitch shorter than the debounce length
    pulses = 0;
    for (int j = 0; j < 15; j++) begin
      cyc((j < 3) ? 1'b0 : 1'b1);
      check($sformatf("gl_held_%0d", j), 8'(b_held), 8'd0);
    end
    check("gl_pulses", 8'(pulses), 8'd0);

    // Press, release, re-press with load register capture
    pulses = 0;
    load_i = 4'hA;
    for (int j = 0; j < 15; j++) begin
      cyc(1'b0);
      if (j == 6) check("load_before", 8'(load_q), 8'h0);
      if (j == 7) check("load_after", 8'(load_q), 8'hA);
    end
    for (int j = 0; j < 15; j++) cyc(1'b1);
    for (int j = 0; j < 15; j++) cyc(1'b0);
    check("repress_pulses", 8'(pulses), 8'd2);
    for (int j = 0; j < 15; j++) cyc(1'b1);

    // Reset mid-press while in S_WAIT
    for (int j = 0; j < 10; j++) cyc(1'b0);
    check("mid_pre_state", 8'(dut.state), 8'(S_WAIT));
    rst = 1'b0;
    cyc(1'b0);
    check("mid_rst_state", 8'(dut.state), 8'(S_INIT));
    check("mid_rst_held", 8'(b_held), 8'd0);
    check("mid_rst_out", 8'(b_out), 8'd0);
    rst = 1'b1;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      cyc(1'b0);
      check($sformatf("mid_out_%0d", j), 8'(b_out), 8'(j == 6));
    end
    check("mid_pulses", 8'(pulses), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
